ram_fifo_ctrl: RTL and testbench

Stream FIFO controller that owns the pointers, occupancy and read pipeline for an external dual-port RAM configured with a registered read port (one-cycle read latency). The producer pushes into it through a valid/ready port. It drives the RAM write and read ports, and returns RAM read data to a consumer through a valid/ready port with a two-entry output buffer, sustaining one transfer per cycle. It is the address/control stage sitting directly in front of the RAM in queue and staging-buffer paths.

---
 rtl/ram_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_fifo_ctrl
// Purpose  : Stream FIFO controller for an external dual-port RAM that has a
//            registered read port (one-cycle read latency). Owns the write and
//            read pointers, the RAM occupancy, the read pipeline and a two-entry
//            output buffer (head + skid) so the consumer sees one transfer per
//            cycle.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous reset, active low
//            enq_*      - producer valid/ready/data
//            deq_*      - consumer valid/ready/data
//            ram_wren/ram_waddr/ram_wdata - RAM write port
//            ram_rden/ram_raddr/ram_rdata - RAM read port (rdata next cycle)
//            count      - total occupancy: RAM + in-flight read + output buffer
// Revision : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl #(
  parameter int DATAW = 32,
  parameter int DEPTH = 16,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_valid,
  input  logic [DATAW-1:0] enq_data,
  output logic             enq_ready,
  output logic             deq_valid,
  output logic [DATAW-1:0] deq_data,
  input  logic             deq_ready,
  output logic             ram_wren,
  output logic [ADDRW-1:0] ram_waddr,
  output logic [DATAW-1:0] ram_wdata,
  output logic             ram_rden,
  output logic [ADDRW-1:0] ram_raddr,
  input  logic [DATAW-1:0] ram_rdata,
  output logic [ADDRW+1:0] count
);

  localparam logic [ADDRW:0] C_FULL = (ADDRW+1)'(DEPTH);

  logic [ADDRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRW:0]   ram_cnt_q, ram_cnt_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       obuf_cnt_q, obuf_cnt_d;
  logic [DATAW-1:0] head_q, head_d;
  logic [DATAW-1:0] skid_q, skid_d;

  logic             w_enq_fire;
  logic             w_deq_fire;
  logic [1:0]       w_obuf_after_deq;
  logic [1:0]       w_pending;

  always_comb begin
    // Space is judged from registered state only, so a read issued this cycle
    // never frees a slot for this cycle's enqueue.
    enq_ready  = (ram_cnt_q != C_FULL);
    w_enq_fire = enq_valid && enq_ready;
    ram_wren   = w_enq_fire;
    ram_waddr  = wr_ptr_q;
    ram_wdata  = enq_data;

    deq_valid  = (obuf_cnt_q != 2'd0);
    deq_data   = head_q;
    w_deq_fire = deq_valid && deq_ready;

    // Entries that will still sit in, or are heading to, the output buffer
    // after this cycle. A new read is only issued if it is guaranteed a slot.
    w_obuf_after_deq = obuf_cnt_q - {1'b0, w_deq_fire};
    w_pending        = w_obuf_after_deq + {1'b0, inflight_q};

    ram_rden  = (ram_cnt_q != '0) && (w_pending < 2'd2);
    ram_raddr = rd_ptr_q;

    wr_ptr_d   = wr_ptr_q + {{(ADDRW-1){1'b0}}, w_enq_fire};
    rd_ptr_d   = rd_ptr_q + {{(ADDRW-1){1'b0}}, ram_rden};
    ram_cnt_d  = ram_cnt_q + {{ADDRW{1'b0}}, w_enq_fire} - {{ADDRW{1'b0}}, ram_rden};
    inflight_d = ram_rden;

    // Output buffer: dequeue shifts skid into head first, then returning read
    // data lands in the first free slot, which keeps FIFO order.
    head_d     = head_q;
    skid_d     = skid_q;
    obuf_cnt_d = w_obuf_after_deq;
    if (w_deq_fire) begin
      head_d = skid_q;
    end
    if (inflight_q) begin
      if (w_obuf_after_deq == 2'd0) begin
        head_d = ram_rdata;
      end else begin
        skid_d = ram_rdata;
      end
      obuf_cnt_d = w_obuf_after_deq + 2'd1;
    end

    count = {1'b0, ram_cnt_q} + {{(ADDRW+1){1'b0}}, inflight_q}
          + {{ADDRW{1'b0}}, obuf_cnt_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      obuf_cnt_q <= 2'd0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      obuf_cnt_q <= obuf_cnt_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_fifo_ctrl
// Purpose  : Self-checking bench for ram_fifo_ctrl with a behavioural RAM and a
//            queue-based reference model of the FIFO contents.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;

  localparam int DATAW = 32;
  localparam int DEPTH = 16;
  localparam int ADDRW = $clog2(DEPTH);

  logic             clk;
  logic             reset;
  logic             enq_valid;
  logic [DATAW-1:0] enq_data;
  logic             enq_ready;
  logic             deq_valid;
  logic [DATAW-1:0] deq_data;
  logic             deq_ready;
  logic             ram_wren;
  logic [ADDRW-1:0] ram_waddr;
  logic [DATAW-1:0] ram_wdata;
  logic             ram_rden;
  logic [ADDRW-1:0] ram_raddr;
  logic [DATAW-1:0] ram_rdata;
  logic [ADDRW+1:0] count;

  ram_fifo_ctrl #(.DATAW(DATAW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .deq_ready (deq_ready),
    .ram_wren  (ram_wren),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_rden  (ram_rden),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with a registered read port.
  logic [DATAW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_waddr] <= ram_wdata;
    if (ram_rden) ram_rdata <= mem[ram_raddr];
  end

  int total = 0;
  int bad   = 0;

  // Reference model: the FIFO is just an ordered list of accepted payloads.
  logic [DATAW-1:0] q [$];
  int               wr_count;
  int               rd_issued;
  logic             stall_prev;
  logic [DATAW-1:0] stall_data;

  // Per-cycle snapshot, taken at the falling edge.
  logic             s_enq_ready, s_deq_valid, s_wren, s_rden;
  logic             s_enq_fire, s_deq_fire;
  logic [DATAW-1:0] s_deq_data, s_wdata, last_pop;
  logic [ADDRW-1:0] s_waddr, s_raddr;
  logic [ADDRW+1:0] s_count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    wr_count   = 0;
    rd_issued  = 0;
    stall_prev = 1'b0;
    stall_data = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    s_enq_ready = enq_ready;
    s_deq_valid = deq_valid;
    s_deq_data  = deq_data;
    s_count     = count;
    s_wren      = ram_wren;
    s_waddr     = ram_waddr;
    s_wdata     = ram_wdata;
    s_rden      = ram_rden;
    s_raddr     = ram_raddr;
    s_enq_fire  = enq_valid && s_enq_ready;
    s_deq_fire  = s_deq_valid && deq_ready;

    chk("count", 64'(s_count), 64'(q.size()));
    chk("capacity", 64'(q.size() <= DEPTH + 2), 64'd1);
    if (!s_enq_ready) chk("ready_low_occ", 64'(q.size() >= DEPTH), 64'd1);
    chk("wren", 64'(s_wren), 64'(s_enq_fire));
    if (s_wren) begin
      chk("waddr", 64'(s_waddr), 64'(wr_count % DEPTH));
      chk("wdata", 64'(s_wdata), 64'(enq_data));
    end
    if (s_rden) begin
      chk("raddr", 64'(s_raddr), 64'(rd_issued % DEPTH));
      chk("rd_avail", 64'(rd_issued < wr_count), 64'd1);
      rd_issued++;
    end
    if (s_deq_valid) begin
      chk("deq_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) chk("deq_data", 64'(s_deq_data), 64'(q[0]));
    end
    if (stall_prev) begin
      chk("stall_valid", 64'(s_deq_valid), 64'd1);
      chk("stall_data", 64'(s_deq_data), 64'(stall_data));
    end
    stall_prev = s_deq_valid && !deq_ready;
    stall_data = s_deq_data;

    if (s_enq_fire) begin
      q.push_back(enq_data);
      wr_count++;
    end
    if (s_deq_fire && q.size() != 0) last_pop = q.pop_front();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    reset     = 1'b0;
    #2;
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rden", 64'(ram_rden), 64'd0);
    chk("rst_wren", 64'(ram_wren), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    clear_model();
  endtask

  task automatic drain(input string tag);
    int n;
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  initial begin
    int accepted;
    int pop_idx;
    int n;
    logic got;

    enq_data = '0;
    clear_model();
    last_pop = '0;
    reset_dut();

    // Single push into an empty FIFO: latency and occupancy.
    enq_valid = 1'b1;
    enq_data  = 32'hA5A5_0001;
    tick();
    chk("t1_c0_wren", 64'(s_wren), 64'd1);
    chk("t1_c0_waddr", 64'(s_waddr), 64'd0);
    enq_valid = 1'b0;
    tick();
    chk("t1_c1_rden", 64'(s_rden), 64'd1);
    chk("t1_c1_raddr", 64'(s_raddr), 64'd0);
    chk("t1_c1_count", 64'(s_count), 64'd1);
    tick();
    chk("t1_c2_valid", 64'(s_deq_valid), 64'd0);
    chk("t1_c2_count", 64'(s_count), 64'd1);
    deq_ready = 1'b1;
    tick();
    chk("t1_c3_valid", 64'(s_deq_valid), 64'd1);
    chk("t1_c3_data", 64'(s_deq_data), 64'hA5A5_0001);
    chk("t1_c3_count", 64'(s_count), 64'd1);
    deq_ready = 1'b0;
    tick();
    chk("t1_after_count", 64'(s_count), 64'd0);

    // Fill with the consumer stalled.
    reset_dut();
    accepted = 0;
    n = 0;
    enq_valid = 1'b1;
    while (accepted < 18 && n < 60) begin
      enq_data = 32'(accepted);
      tick();
      if (s_enq_fire) accepted++;
      n++;
    end
    chk("fill_accepts", 64'(accepted), 64'd18);
    enq_data = 32'd18;
    repeat (3) begin
      tick();
      chk("full_ready", 64'(s_enq_ready), 64'd0);
      chk("full_rden", 64'(s_rden), 64'd0);
    end
    chk("full_count", 64'(s_count), 64'd18);
    chk("fill_reads", 64'(rd_issued), 64'd2);

    // Full boundary: the read issued this cycle does not admit an enqueue.
    pop_idx   = 0;
    deq_ready = 1'b1;
    tick();
    chk("bnd_wren", 64'(s_wren), 64'd0);
    chk("bnd_rden", 64'(s_rden), 64'd1);
    if (s_deq_fire) begin
      chk("bnd_pop", 64'(last_pop), 64'(pop_idx));
      pop_idx++;
    end
    tick();
    chk("bnd_resume_ready", 64'(s_enq_ready), 64'd1);
    chk("bnd_resume_wren", 64'(s_wren), 64'd1);
    if (s_deq_fire) begin
      chk("bnd_pop", 64'(last_pop), 64'(pop_idx));
      pop_idx++;
    end
    enq_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      tick();
      if (s_deq_fire) begin
        chk("drain_order", 64'(last_pop), 64'(pop_idx));
        pop_idx++;
      end
      n++;
    end
    chk("drain_total", 64'(pop_idx), 64'd19);

    // Streaming: one in, one out per cycle once primed.
    reset_dut();
    for (int c = 0; c < 100; c++) begin
      enq_valid = 1'b1;
      deq_ready = 1'b1;
      enq_data  = 32'h1000 + 32'(c);
      tick();
      chk("stream_ready", 64'(s_enq_ready), 64'd1);
      if (c >= 3) chk("stream_valid", 64'(s_deq_valid), 64'd1);
      else        chk("stream_prime", 64'(s_deq_valid), 64'd0);
    end
    drain("stream_drain");

    // Random handshakes on both sides.
    for (int c = 0; c < 10000; c++) begin
      enq_valid = 1'($urandom_range(1));
      deq_ready = 1'($urandom_range(1));
      enq_data  = $urandom;
      tick();
    end
    drain("rand_drain");

    // Reset mid-operation with one read in flight.
    reset_dut();
    enq_valid = 1'b1;
    accepted  = 0;
    n = 0;
    while (accepted < 10 && n < 40) begin
      enq_data = 32'hB000 + 32'(accepted);
      tick();
      if (s_enq_fire) accepted++;
      n++;
    end
    enq_valid = 1'b0;
    repeat (4) tick();
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    #1;
    chk("pre_rst_count", 64'(count), 64'd9);
    reset = 1'b0;
    #1;
    chk("arst_deq_valid", 64'(deq_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_enq_ready", 64'(enq_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_model();
    enq_valid = 1'b1;
    enq_data  = 32'h1234;
    tick();
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 10) begin
      tick();
      if (s_deq_fire) got = 1'b1;
      n++;
    end
    chk("post_rst_got", 64'(got), 64'd1);
    chk("post_rst_data", 64'(last_pop), 64'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
